// File: rtl/ysyx_22050133_inst_fetch.sv
// rtl/ysyx_22050133_inst_fetch.sv - single-outstanding AXI4 instruction fetch unit
// Owns the fetch PC, issues one-beat reads and hands {pc, inst} to decode.
module ysyx_22050133_inst_fetch #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter logic [3:0]  AXI_ID   = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [63:0] pc,
  output logic [31:0] inst,
  output logic        fetch_err,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  output logic [63:0] axi_araddr,
  output logic [3:0]  axi_arid,
  output logic [7:0]  axi_arlen,
  output logic [2:0]  axi_arsize,
  output logic [1:0]  axi_arburst,
  input  logic        axi_rvalid,
  output logic        axi_rready,
  input  logic [63:0] axi_rdata,
  input  logic [1:0]  axi_rresp,
  input  logic        axi_rlast,
  input  logic [3:0]  axi_rid
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, HOLD} state_t;

  state_t      state;
  logic [63:0] fetch_pc;
  logic [63:0] pend_pc;
  logic        discard;
  logic [63:0] target;

  assign target      = {redirect_pc[63:2], 2'b00};
  assign pc          = fetch_pc;
  assign axi_araddr  = fetch_pc;
  assign axi_arid    = AXI_ID;
  assign axi_arlen   = 8'd0;
  assign axi_arsize  = 3'b010;
  assign axi_arburst = 2'b01;

  logic unused_inputs;
  assign unused_inputs = &{1'b0, axi_rlast, axi_rid, redirect_pc[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      pend_pc     <= 64'd0;
      discard     <= 1'b0;
      inst        <= 32'd0;
      fetch_err   <= 1'b0;
      inst_valid  <= 1'b0;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_valid) fetch_pc <= target;
          state       <= REQ;
          axi_arvalid <= 1'b1;
        end
        REQ: begin
          // The AR cannot be withdrawn, so a redirect only marks its response for dropping.
          if (redirect_valid) begin
            discard <= 1'b1;
            pend_pc <= target;
          end
          if (axi_arready) begin
            state       <= RESP;
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b1;
          end
        end
        RESP: begin
          if (axi_rvalid) begin
            axi_rready <= 1'b0;
            if (redirect_valid || discard) begin
              fetch_pc    <= redirect_valid ? target : pend_pc;
              discard     <= 1'b0;
              state       <= REQ;
              axi_arvalid <= 1'b1;
            end else begin
              inst       <= fetch_pc[2] ? axi_rdata[63:32] : axi_rdata[31:0];
              fetch_err  <= (axi_rresp != 2'b00);
              state      <= HOLD;
              inst_valid <= 1'b1;
            end
          end else if (redirect_valid) begin
            discard <= 1'b1;
            pend_pc <= target;
          end
        end
        HOLD: begin
          // A redirect beats a same-cycle accept: decode is flushed by the same event.
          if (redirect_valid || inst_ready) begin
            fetch_pc    <= redirect_valid ? target : fetch_pc + 64'd4;
            state       <= REQ;
            inst_valid  <= 1'b0;
            axi_arvalid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050133_inst_fetch.sv
// tb/tb_ysyx_22050133_inst_fetch.sv - scoreboard bench for the instruction fetch unit
module tb_ysyx_22050133_inst_fetch;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'd0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [63:0] pc;
  logic [31:0] inst;
  logic        fetch_err;
  logic        axi_arvalid;
  logic        axi_arready = 1'b0;
  logic [63:0] axi_araddr;
  logic [3:0]  axi_arid;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic        axi_rvalid;
  logic        axi_rready;
  logic [63:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast = 1'b1;
  logic [3:0]  axi_rid = 4'd0;

  logic        r_en = 1'b0;
  logic [1:0]  rresp_val = 2'b00;
  logic        have_req;
  logic [63:0] addr_q;

  int checks = 0;
  int errors = 0;

  logic [63:0] ar_q[$];
  logic [96:0] inst_q[$];

  ysyx_22050133_inst_fetch dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .pc(pc), .inst(inst), .fetch_err(fetch_err),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
    .axi_arid(axi_arid), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
    .axi_rresp(axi_rresp), .axi_rlast(axi_rlast), .axi_rid(axi_rid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  // Memory slave: one outstanding read, data derived from the captured address
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      have_req <= 1'b0;
      addr_q   <= 64'd0;
    end else if (axi_arvalid && axi_arready) begin
      have_req <= 1'b1;
      addr_q   <= axi_araddr;
    end else if (axi_rvalid && axi_rready) begin
      have_req <= 1'b0;
    end
  end

  assign axi_rvalid = have_req && r_en;
  assign axi_rdata  = {word({addr_q[63:3], 3'b100}), word({addr_q[63:3], 3'b000})};
  assign axi_rresp  = rresp_val;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_inst(input logic [63:0] a, input logic err);
    inst_q.push_back({err, a, word(a)});
  endtask

  // Monitors: sample mid-cycle, pop expectations on each handshake
  always @(negedge clk) begin
    if (rst && axi_arvalid && axi_arready) begin
      if (ar_q.size() == 0) chk("ar_unexpected", axi_araddr, 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("araddr", axi_araddr, ar_q.pop_front());
    end
  end

  always @(negedge clk) begin
    logic [96:0] e;
    if (rst && inst_valid && inst_ready && !redirect_valid) begin
      if (inst_q.size() == 0) chk("inst_unexpected", pc, 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        e = inst_q.pop_front();
        chk("xfer_pc", pc, e[95:32]);
        chk("xfer_inst", {32'd0, inst}, {32'd0, e[31:0]});
        chk("xfer_err", {63'd0, fetch_err}, {63'd0, e[96]});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!inst_valid && n < 20) begin
      step(1);
      n++;
    end
    chk("wait_valid", {63'd0, inst_valid}, 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    step(2);
    chk("rst_arvalid", {63'd0, axi_arvalid}, 64'd0);
    chk("rst_rready", {63'd0, axi_rready}, 64'd0);
    chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_inst", {32'd0, inst}, 64'd0);
    chk("rst_fetch_err", {63'd0, fetch_err}, 64'd0);
    chk("const_ar", {47'd0, axi_arid, axi_arlen, axi_arsize, axi_arburst},
        {47'd0, 4'd0, 8'd0, 3'b010, 2'b01});

    // 1: back-to-back fetches, latency 3
    ar_q.push_back(64'h8000_0000);
    ar_q.push_back(64'h8000_0004);
    ar_q.push_back(64'h8000_0008);
    push_inst(64'h8000_0000, 1'b0);
    push_inst(64'h8000_0004, 1'b0);
    push_inst(64'h8000_0008, 1'b0);
    axi_arready = 1'b1; r_en = 1'b1; inst_ready = 1'b1;
    rst = 1'b1;
    step(2);
    chk("latency_lo", {63'd0, inst_valid}, 64'd0);
    step(1);
    chk("latency_hi", {63'd0, inst_valid}, 64'd1);
    chk("first_inst", {32'd0, inst}, {32'd0, 32'h9357_9BDF});
    step(1);
    wait_valid();
    chk("upper_half", {32'd0, inst}, {32'd0, 32'h9357_9BDB});
    step(1);
    inst_ready = 1'b0;
    wait_valid();

    // 2: decode stall keeps the instruction stable
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("hold_valid", {63'd0, inst_valid}, 64'd1);
      chk("hold_pc", pc, 64'h8000_0008);
      chk("hold_inst", {32'd0, inst}, {32'd0, 32'h9357_9BD7});
      chk("hold_arvalid", {63'd0, axi_arvalid}, 64'd0);
    end
    inst_ready = 1'b1;
    step(1);
    axi_arready = 1'b0;
    rst = 1'b0;
    step(2);
    chk("rst2_arvalid", {63'd0, axi_arvalid}, 64'd0);

    // 3: redirect during a stalled AR; 4: redirect with inst_ready in HOLD
    ar_q.push_back(64'h8000_0000);
    ar_q.push_back(64'h8000_1000);
    ar_q.push_back(64'h8000_1004);
    ar_q.push_back(64'h8000_2000);
    push_inst(64'h8000_1000, 1'b0);
    push_inst(64'h8000_2000, 1'b0);
    rst = 1'b1;
    step(1);
    for (int i = 0; i < 4; i++) begin
      redirect_valid = (i == 1);
      redirect_pc    = 64'h8000_1003;
      chk("stall_arvalid", {63'd0, axi_arvalid}, 64'd1);
      chk("stall_araddr", axi_araddr, 64'h8000_0000);
      step(1);
    end
    redirect_valid = 1'b0;
    axi_arready = 1'b1;
    wait_valid();
    chk("redir_pc", pc, 64'h8000_1000);
    step(1);
    inst_ready = 1'b0;
    wait_valid();
    chk("held_pc", pc, 64'h8000_1004);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_2000; inst_ready = 1'b1;
    step(1);
    redirect_valid = 1'b0; inst_ready = 1'b0;
    chk("flush_valid", {63'd0, inst_valid}, 64'd0);
    chk("flush_araddr", axi_araddr, 64'h8000_2000);
    wait_valid();
    chk("redir2_pc", pc, 64'h8000_2000);

    // 5: error response still delivers the selected half
    rresp_val = 2'b10;
    ar_q.push_back(64'h8000_2004);
    push_inst(64'h8000_2004, 1'b1);
    inst_ready = 1'b1;
    step(1);
    inst_ready = 1'b0;
    wait_valid();
    chk("err_flag", {63'd0, fetch_err}, 64'd1);
    chk("err_inst", {32'd0, inst}, {32'd0, 32'h9357_BBDB});
    inst_ready = 1'b1;
    step(1);
    inst_ready = 1'b0; axi_arready = 1'b0; rresp_val = 2'b00;

    // 6: reset asserted while waiting for R
    r_en = 1'b0; axi_arready = 1'b1;
    ar_q.push_back(64'h8000_2008);
    step(1);
    axi_arready = 1'b0;
    chk("resp_rready", {63'd0, axi_rready}, 64'd1);
    rst = 1'b0;
    #1;
    chk("async_arvalid", {63'd0, axi_arvalid}, 64'd0);
    chk("async_rready", {63'd0, axi_rready}, 64'd0);
    chk("async_valid", {63'd0, inst_valid}, 64'd0);
    chk("async_pc", pc, RESET_PC);
    ar_q.push_back(64'h8000_0000);
    push_inst(64'h8000_0000, 1'b0);
    step(1);
    chk("inrst_arvalid", {63'd0, axi_arvalid}, 64'd0);
    r_en = 1'b1; axi_arready = 1'b1;
    rst = 1'b1;
    wait_valid();
    inst_ready = 1'b1;
    step(1);
    inst_ready = 1'b0; axi_arready = 1'b0;
    step(3);

    chk("ar_q_drained", 64'(ar_q.size()), 64'd0);
    chk("inst_q_drained", 64'(inst_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
